// File: rtl/rst_pkg.sv
// Shared types for the reset sequencer: FSM states and the recorded cause of the last sequence.
package rst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2,
        ACK     = 2'd3
    } rst_state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'b00,
        CAUSE_SW  = 2'b01,
        CAUSE_WDT = 2'b10
    } rst_cause_e;

endpackage

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds every domain in reset for PULSE_CYCLES cycles, then releases the
// domains one at a time, STAGGER_CYCLES apart, starting with bit 0, and acknowledges completion.
module rst_seq_ctrl
    import rst_pkg::*;
#(
    parameter int PULSE_CYCLES   = 16,
    parameter int NUM_DOMAINS    = 3,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   sw_rst_req_i,
    input  logic                   wdt_rst_req_i,
    output logic [NUM_DOMAINS-1:0] rst_o,
    output logic                   busy_o,
    output logic                   rst_ack_o,
    output logic [1:0]             rst_cause_o,
    output rst_state_e             dbg_state_o
);

    localparam int REL_SPAN = (NUM_DOMAINS - 1) * STAGGER_CYCLES;
    localparam int CNT_MAX  = (PULSE_CYCLES > REL_SPAN + 1) ? PULSE_CYCLES : REL_SPAN + 1;
    localparam int CNT_W    = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] REL_LAST   = CNT_W'(REL_SPAN);

    rst_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    rst_cause_e             r_cause;
    logic [NUM_DOMAINS-1:0] r_rst;
    logic                   r_busy;
    logic                   r_ack;

    rst_state_e             w_state_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    rst_cause_e             w_cause_nxt;
    logic [NUM_DOMAINS-1:0] w_rst_nxt;
    logic                   w_busy_nxt;
    logic                   w_ack_nxt;
    logic                   w_req;

    assign w_req = sw_rst_req_i | wdt_rst_req_i;

    // Outputs are computed from the next state so every port can come straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cause_nxt = r_cause;
        w_rst_nxt   = '0;
        w_busy_nxt  = 1'b0;
        w_ack_nxt   = 1'b0;

        case (r_state)
            IDLE, ACK: begin
                if (w_req) begin
                    w_state_nxt = ASSERT;
                    w_cnt_nxt   = '0;
                    if (wdt_rst_req_i) begin
                        w_cause_nxt = CAUSE_WDT;
                    end else begin
                        w_cause_nxt = CAUSE_SW;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            ASSERT: begin
                if (r_cnt == PULSE_LAST) begin
                    w_state_nxt = RELEASE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                // Only the watchdog may restart a sequence once release has begun.
                if (wdt_rst_req_i) begin
                    w_state_nxt = ASSERT;
                    w_cnt_nxt   = '0;
                    w_cause_nxt = CAUSE_WDT;
                end else if (r_cnt == REL_LAST) begin
                    w_state_nxt = ACK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        case (w_state_nxt)
            ASSERT: begin
                w_rst_nxt  = '1;
                w_busy_nxt = 1'b1;
            end
            RELEASE: begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    w_rst_nxt[i] = (int'(w_cnt_nxt) < i * STAGGER_CYCLES);
                end
                w_busy_nxt = 1'b1;
            end
            ACK: begin
                w_ack_nxt = 1'b1;
            end
            default: begin
                w_rst_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ASSERT;
            r_cnt   <= '0;
            r_cause <= CAUSE_POR;
            r_rst   <= '1;
            r_busy  <= 1'b1;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cause <= w_cause_nxt;
            r_rst   <= w_rst_nxt;
            r_busy  <= w_busy_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    assign rst_o       = r_rst;
    assign busy_o      = r_busy;
    assign rst_ack_o   = r_ack;
    assign rst_cause_o = r_cause;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl: default-parameter instance plus a PULSE=1/DOMAINS=1 corner instance.
module tb_rst_seq_ctrl;
    import rst_pkg::*;

    logic       clk_i;
    logic       rst_i;
    logic       sw_rst_req_i;
    logic       wdt_rst_req_i;
    logic [2:0] rst_o;
    logic       busy_o;
    logic       rst_ack_o;
    logic [1:0] rst_cause_o;
    rst_state_e dbg_state_o;

    logic       c_sw;
    logic       c_wdt;
    logic [0:0] c_rst_o;
    logic       c_busy;
    logic       c_ack;
    logic [1:0] c_cause;
    rst_state_e c_state;

    int vectors     = 0;
    int miscompares = 0;

    rst_seq_ctrl #(.PULSE_CYCLES(16), .NUM_DOMAINS(3), .STAGGER_CYCLES(4)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sw_rst_req_i  (sw_rst_req_i),
        .wdt_rst_req_i (wdt_rst_req_i),
        .rst_o         (rst_o),
        .busy_o        (busy_o),
        .rst_ack_o     (rst_ack_o),
        .rst_cause_o   (rst_cause_o),
        .dbg_state_o   (dbg_state_o)
    );

    rst_seq_ctrl #(.PULSE_CYCLES(1), .NUM_DOMAINS(1), .STAGGER_CYCLES(1)) dut_c (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sw_rst_req_i  (c_sw),
        .wdt_rst_req_i (c_wdt),
        .rst_o         (c_rst_o),
        .busy_o        (c_busy),
        .rst_ack_o     (c_ack),
        .rst_cause_o   (c_cause),
        .dbg_state_o   (c_state)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Walks a sequence from its first ASSERT cycle (a=0); default timing is 16 asserted
    // cycles, releases at a=16/20/24, ack at a=25. Inputs set at cycle a land at a+1.
    task automatic run_seq(input string name, input logic [1:0] exp_cause,
                           input int sw_at, input int wdt_at, input int rst_at, input int last_a);
        logic [2:0] exp_rst;
        rst_state_e exp_st;
        for (int a = 0; a <= last_a; a++) begin
            exp_rst = (a < 16) ? 3'b111 : (a < 20) ? 3'b110 : (a < 24) ? 3'b100 : 3'b000;
            exp_st  = (a < 16) ? ASSERT : (a < 25) ? RELEASE : ACK;
            chk($sformatf("%s a=%0d rst_o", name, a), 32'(rst_o), 32'(exp_rst));
            chk($sformatf("%s a=%0d busy_o", name, a), 32'(busy_o), 32'(a < 25));
            chk($sformatf("%s a=%0d rst_ack_o", name, a), 32'(rst_ack_o), 32'(a == 25));
            chk($sformatf("%s a=%0d cause", name, a), 32'(rst_cause_o), 32'(exp_cause));
            chk($sformatf("%s a=%0d state", name, a), 32'(dbg_state_o), 32'(exp_st));
            sw_rst_req_i  = (a == sw_at);
            wdt_rst_req_i = (a == wdt_at);
            rst_i         = (a == rst_at);
            @(negedge clk_i);
        end
        sw_rst_req_i  = 1'b0;
        wdt_rst_req_i = 1'b0;
        rst_i         = 1'b0;
    endtask

    task automatic chk_idle(input string name, input logic [1:0] exp_cause);
        chk({name, " rst_o"}, 32'(rst_o), 32'(3'b000));
        chk({name, " busy_o"}, 32'(busy_o), 32'(1'b0));
        chk({name, " rst_ack_o"}, 32'(rst_ack_o), 32'(1'b0));
        chk({name, " cause"}, 32'(rst_cause_o), 32'(exp_cause));
        chk({name, " state"}, 32'(dbg_state_o), 32'(IDLE));
    endtask

    initial begin
        rst_i         = 1'b1;
        sw_rst_req_i  = 1'b0;
        wdt_rst_req_i = 1'b0;
        c_sw          = 1'b0;
        c_wdt         = 1'b0;

        // Power-on: two reset edges, then cycle 0 is the first cycle with rst_i low.
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        run_seq("por", 2'b00, -1, -1, -1, 25);
        chk_idle("por idle", 2'b00);
        repeat (3) @(negedge clk_i);
        chk_idle("por idle held", 2'b00);

        // Single-cycle software request from IDLE.
        sw_rst_req_i = 1'b1;
        @(negedge clk_i);
        run_seq("sw", 2'b01, -1, -1, -1, 25);
        chk_idle("sw idle", 2'b01);

        // Simultaneous requests record WDT; requests during ASSERT are dropped.
        sw_rst_req_i  = 1'b1;
        wdt_rst_req_i = 1'b1;
        @(negedge clk_i);
        run_seq("both", 2'b10, 5, 9, -1, 25);
        chk_idle("both idle", 2'b10);

        // Watchdog during RELEASE at cnt=5 (a=21) restarts the sequence.
        sw_rst_req_i = 1'b1;
        @(negedge clk_i);
        run_seq("wdt_pre", 2'b01, -1, 21, -1, 21);
        run_seq("wdt_restart", 2'b10, -1, -1, -1, 25);
        chk_idle("wdt idle", 2'b10);

        // Software request during RELEASE is ignored.
        sw_rst_req_i = 1'b1;
        @(negedge clk_i);
        run_seq("sw_in_rel", 2'b01, 18, -1, -1, 25);
        chk_idle("sw_in_rel idle", 2'b01);

        // rst_i pulse during RELEASE aborts and replays the POR sequence.
        wdt_rst_req_i = 1'b1;
        @(negedge clk_i);
        run_seq("rst_pre", 2'b10, -1, -1, 18, 18);
        run_seq("rst_restart", 2'b00, -1, -1, -1, 25);
        chk_idle("rst idle", 2'b00);

        // Corner instance: request at t -> reset at t+1, released at t+2, ack at t+3.
        chk("corner idle state", 32'(c_state), 32'(IDLE));
        c_sw = 1'b1;
        @(negedge clk_i);
        c_sw = 1'b0;
        chk("corner t+1 rst_o", 32'(c_rst_o), 32'(1'b1));
        chk("corner t+1 busy_o", 32'(c_busy), 32'(1'b1));
        chk("corner t+1 state", 32'(c_state), 32'(ASSERT));
        chk("corner t+1 cause", 32'(c_cause), 32'(2'b01));
        @(negedge clk_i);
        chk("corner t+2 rst_o", 32'(c_rst_o), 32'(1'b0));
        chk("corner t+2 busy_o", 32'(c_busy), 32'(1'b1));
        chk("corner t+2 rst_ack_o", 32'(c_ack), 32'(1'b0));
        @(negedge clk_i);
        chk("corner t+3 rst_ack_o", 32'(c_ack), 32'(1'b1));
        chk("corner t+3 busy_o", 32'(c_busy), 32'(1'b0));
        chk("corner t+3 rst_o", 32'(c_rst_o), 32'(1'b0));
        @(negedge clk_i);
        chk("corner t+4 rst_ack_o", 32'(c_ack), 32'(1'b0));
        chk("corner t+4 state", 32'(c_state), 32'(IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rst_seq_ctrl.md
RST_SEQ_CTRL -- requirements
Module: rst_seq_ctrl

Interface
REQ-001 Parameter PULSE_CYCLES, default 16: cycles all domain resets stay asserted per sequence; legal range >=1.
REQ-002 Parameter NUM_DOMAINS, default 3: number of staggered reset outputs; legal range >=1.
REQ-003 Parameter STAGGER_CYCLES, default 4: cycles between successive domain releases; legal range >=1.
REQ-004 clk_i  input  1  single clock for all logic.
REQ-005 rst_i  input  1  reset; synchronous and active-high.
REQ-006 sw_rst_req_i  input  1  software reset request, level-sampled each cycle.
REQ-007 wdt_rst_req_i  input  1  watchdog reset request, level-sampled each cycle.
REQ-008 rst_o  output  NUM_DOMAINS  active-high domain resets; bit 0 is released first.
REQ-009 busy_o  output  1  high while a sequence is in ASSERT or RELEASE.
REQ-010 rst_ack_o  output  1  one-cycle pulse when a sequence completes.
REQ-011 rst_cause_o  output  2  cause of the last sequence: 00 POR, 01 SW, 10 WDT; 11 is never driven.

Function
REQ-012 FSM states SHALL be IDLE, ASSERT, RELEASE and ACK, with one counter cnt sized $clog2(max(PULSE_CYCLES, (NUM_DOMAINS-1)*STAGGER_CYCLES+1))+1 bits.
REQ-013 IDLE/ACK: any request sampled high SHALL move to ASSERT next cycle with cnt=0, and cause latched WDT if wdt_rst_req_i is high, else SW.
REQ-014 ASSERT: rst_o SHALL be all ones; cnt increments; at cnt==PULSE_CYCLES-1 go to RELEASE with cnt=0, giving exactly PULSE_CYCLES asserted cycles.
REQ-015 RELEASE: rst_o[i] SHALL be 0 when cnt>=i*STAGGER_CYCLES, else 1; at cnt==(NUM_DOMAINS-1)*STAGGER_CYCLES go to ACK.
REQ-016 ACK: rst_o all zeros, rst_ack_o=1 for that single cycle, busy_o=0; without a request, next state is IDLE.
REQ-017 busy_o SHALL be 1 exactly in ASSERT and RELEASE; rst_ack_o SHALL be 1 only in ACK.
REQ-018 wdt_rst_req_i high during RELEASE SHALL restart: ASSERT next cycle, cnt=0, all rst_o reasserted, cause=WDT.
REQ-019 wdt_rst_req_i during ASSERT, and sw_rst_req_i during ASSERT or RELEASE, SHALL be ignored (no queuing).
REQ-020 Simultaneous sw and wdt requests SHALL record cause WDT.
REQ-021 rst_o, busy_o, rst_ack_o and rst_cause_o SHALL be driven from flops, with no combinational path from inputs.
REQ-022 rst_cause_o SHALL change only on entry to ASSERT.

Reset
REQ-023 rst_i high at a clock edge SHALL set the following: state ASSERT, cnt=0, rst_o all ones, busy_o=1, rst_ack_o=0, rst_cause_o=00.
REQ-024 rst_i asserted mid-sequence SHALL abort the sequence and restart the POR sequence; the first cycle with rst_i low counts as ASSERT cycle 0.

Structure
REQ-025 Package rst_pkg SHALL hold the state enum (rst_state_e) and the cause encoding (rst_cause_e: CAUSE_POR, CAUSE_SW, CAUSE_WDT).
REQ-026 The block SHALL be single-module with no sub-modules; the FSM and counter share one always_ff.

Verification (defaults 16/3/4; cycle 0 = first cycle with rst_i low)
REQ-027 POR: rst_i high 2 cycles, then low -> rst_o=111 cycles 0-15, 110 at 16, 100 at 20, 000 at 24, rst_ack_o=1 at cycle 25 only, cause=00.
REQ-028 SW request: 1-cycle sw_rst_req_i pulse in IDLE at cycle t -> busy_o=1 from t+1, rst_o=111 for cycles t+1..t+16, ack at t+26, cause=01.
REQ-029 WDT restart: wdt_rst_req_i pulse at RELEASE cycle cnt=5 (rst_o=100) -> next cycle rst_o=111, cnt=0, cause=10, full 16+9 sequence follows.
REQ-030 Simultaneous sw and wdt in IDLE -> cause=10; sw pulse during ASSERT -> no extension, ack still 26 cycles after the original request.
REQ-031 rst_i pulse during RELEASE -> next cycle rst_o=111, cause=00, full POR timing from REQ-027 repeats.
REQ-032 Parameter corner NUM_DOMAINS=1, PULSE_CYCLES=1: request at t -> rst_o=1 at t+1, 0 at t+2, ack at t+3.
